// File: rtl/sampler_pkg.sv
// Shared definitions for the triggered sampler: FSM state encoding.
package sampler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    WAIT = 2'd2,
    POST = 2'd3
  } sampler_state_t;

endpackage

// File: rtl/sampler_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port, single clock.
module sampler_ram #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [WIDTH-1:0] r_rdata;

  // No reset on storage or read register so the array maps onto block RAM;
  // the read register holds its value whenever i_re is low.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/triggered_sampler.sv
// Trigger-based capture engine: keeps pre-trigger history, the trigger sample and the
// post-trigger tail in a circular buffer, read back in logical (oldest-first) order.
module triggered_sampler
  import sampler_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TIME_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     s_in,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     trig_mask,
  input  logic [WIDTH-1:0]     trig_value,
  input  logic                 trig_edge,
  input  logic [TIME_BITS-1:0] pre_count,
  output logic [1:0]           state,
  output logic                 done,
  output logic                 irq,
  input  logic                 irq_clear,
  input  logic                 r_enable,
  input  logic [TIME_BITS-1:0] r_addr,
  output logic [WIDTH-1:0]     r_out,
  output logic [TIME_BITS-1:0] trig_index
);

  localparam int                   DEPTH   = 2**TIME_BITS;
  localparam logic [TIME_BITS-1:0] LastIdx = TIME_BITS'(DEPTH - 1);

  sampler_state_t       r_state;
  logic                 r_done;
  logic                 r_irq;
  logic                 r_prev_cond;
  logic                 r_rd_valid;
  logic [TIME_BITS-1:0] r_waddr;
  logic [TIME_BITS-1:0] r_pre;
  logic [TIME_BITS-1:0] r_remaining;
  logic [TIME_BITS-1:0] r_trig_phys;

  logic                 w_cond;
  logic                 w_trigger;
  logic                 w_start;
  logic                 w_we;
  logic                 w_done_set;
  logic [TIME_BITS-1:0] w_waddr_next;
  logic [TIME_BITS-1:0] w_raddr;
  logic [WIDTH-1:0]     w_rdata;

  assign w_cond       = ((s_in & trig_mask) == (trig_value & trig_mask));
  assign w_trigger    = w_cond && (!trig_edge || !r_prev_cond);
  assign w_waddr_next = r_waddr + 1'b1;

  // Arming is only honoured when idle or finished, and abort always wins.
  assign w_start = arm && !abort && ((r_state == IDLE) || (r_state == POST && r_done));
  assign w_we    = !abort && ((r_state == PRE) || (r_state == WAIT) ||
                              (r_state == POST && !r_done));

  assign w_done_set = !abort &&
                      ((r_state == WAIT && w_trigger && r_pre == LastIdx) ||
                       (r_state == POST && !r_done && r_remaining == 1'b1));

  // Oldest kept sample sits pre entries before the trigger; index math wraps naturally.
  assign w_raddr = r_trig_phys - r_pre + r_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_waddr     <= '0;
      r_pre       <= '0;
      r_remaining <= '0;
      r_trig_phys <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else if (w_start) begin
      r_pre   <= pre_count;
      r_waddr <= '0;
      r_done  <= 1'b0;
      r_state <= (pre_count == '0) ? WAIT : PRE;
    end else begin
      case (r_state)
        PRE: begin
          r_waddr <= w_waddr_next;
          if (w_waddr_next == r_pre) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_waddr <= w_waddr_next;
          if (w_trigger) begin
            r_trig_phys <= r_waddr;
            r_remaining <= LastIdx - r_pre;
            r_state     <= POST;
            if (w_done_set) begin
              r_done <= 1'b1;
            end
          end
        end
        POST: begin
          if (!r_done) begin
            r_waddr     <= w_waddr_next;
            r_remaining <= r_remaining - 1'b1;
            if (w_done_set) begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // prev_cond tracks the condition every cycle; arming primes it so a condition
  // already true at arm time cannot produce an edge trigger.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_cond <= 1'b1;
    end else begin
      r_prev_cond <= w_start ? 1'b1 : w_cond;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (w_done_set) begin
      r_irq <= 1'b1;
    end else if (irq_clear) begin
      r_irq <= 1'b0;
    end
  end

  // The RAM output register carries no reset, so r_out is gated to zero until
  // the first read after reset has loaded it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
    end else if (r_enable) begin
      r_rd_valid <= 1'b1;
    end
  end

  sampler_ram #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (TIME_BITS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_waddr),
    .i_wdata (s_in),
    .i_re    (r_enable),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign state      = r_state;
  assign done       = r_done;
  assign irq        = r_irq;
  assign trig_index = r_pre;
  assign r_out      = r_rd_valid ? w_rdata : '0;

endmodule

// File: tb/tb_triggered_sampler.sv
// Self-checking bench for triggered_sampler (WIDTH=8, TIME_BITS=4) against a
// sample-history model of which DEPTH samples around the trigger are kept.
module tb_triggered_sampler;

  localparam int W     = 8;
  localparam int TB    = 4;
  localparam int DEPTH = 16;
  localparam int N     = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  s_in;
  logic          arm;
  logic          abort;
  logic [W-1:0]  trig_mask;
  logic [W-1:0]  trig_value;
  logic          trig_edge;
  logic [TB-1:0] pre_count;
  logic [1:0]    state;
  logic          done;
  logic          irq;
  logic          irq_clear;
  logic          r_enable;
  logic [TB-1:0] r_addr;
  logic [W-1:0]  r_out;
  logic [TB-1:0] trig_index;

  logic [W-1:0]  hist [N];
  int            nChecks = 0;
  int            nFails  = 0;

  triggered_sampler #(.WIDTH(W), .TIME_BITS(TB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_in       (s_in),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_edge  (trig_edge),
    .pre_count  (pre_count),
    .state      (state),
    .done       (done),
    .irq        (irq),
    .irq_clear  (irq_clear),
    .r_enable   (r_enable),
    .r_addr     (r_addr),
    .r_out      (r_out),
    .trig_index (trig_index)
  );

  always #5 clk = ~clk;

  // Sample k is the k-th sample presented after the arm cycle; the trigger is the first
  // sample at or after index pre whose condition holds (and, in edge mode, did not hold
  // on the previous sample, with "previous" of sample 0 treated as true).
  function automatic int find_trigger(input int pre, input bit edgeMode,
                                      input logic [W-1:0] mask, input logic [W-1:0] value);
    bit prev = 1'b1;
    bit c;
    for (int k = 0; k < N; k++) begin
      c = ((hist[k] ^ value) & mask) == '0;
      if (k >= pre && c && (!edgeMode || !prev)) return k;
      prev = c;
    end
    return -1;
  endfunction

  task automatic run_capture(input int pre, input bit edgeMode, input logic [W-1:0] mask,
                             input logic [W-1:0] value, input bit clrOnDone,
                             input string tag, output int t);
    int last;
    int doneAt = -1;
    t    = find_trigger(pre, edgeMode, mask, value);
    last = t + (DEPTH - 1 - pre);
    @(negedge clk);
    arm = 1'b1; pre_count = pre[TB-1:0]; trig_mask = mask; trig_value = value;
    trig_edge = edgeMode;
    @(posedge clk);
    @(negedge clk);
    arm = 1'b0;
    nChecks++;
    if (state !== ((pre == 0) ? 2'd2 : 2'd1)) begin
      nFails++;
      $display("[TB] FAIL %s state_after_arm: got %0d expected %0d", tag, state, (pre == 0) ? 2 : 1);
    end
    for (int k = 0; k < N; k++) begin
      s_in      = hist[k];
      irq_clear = clrOnDone && (k == last);
      @(posedge clk);
      @(negedge clk);
      irq_clear = 1'b0;
      if (done) begin
        doneAt = k;
        break;
      end
    end
    nChecks++;
    if (doneAt != last) begin
      nFails++;
      $display("[TB] FAIL %s done_sample: got %0d expected %0d", tag, doneAt, last);
    end
    nChecks++;
    if (irq !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL %s irq_after_done: got %b expected 1", tag, irq);
    end
    nChecks++;
    if (state !== 2'd3) begin
      nFails++;
      $display("[TB] FAIL %s state_done: got %0d expected 3", tag, state);
    end
  endtask

  task automatic check_readout(input int t, input int pre, input string tag);
    logic [W-1:0] lastExp = '0;
    nChecks++;
    if (trig_index !== pre[TB-1:0]) begin
      nFails++;
      $display("[TB] FAIL %s trig_index: got %0d expected %0d", tag, trig_index, pre);
    end
    for (int i = 0; i < DEPTH; i++) begin
      r_enable = 1'b1;
      r_addr   = i[TB-1:0];
      @(posedge clk);
      @(negedge clk);
      r_enable = 1'b0;
      lastExp  = hist[t - pre + i];
      nChecks++;
      if (r_out !== lastExp) begin
        nFails++;
        $display("[TB] FAIL %s read[%0d]: got %h expected %h", tag, i, r_out, lastExp);
      end
    end
    r_addr = r_addr + 4'd5;
    @(posedge clk);
    @(negedge clk);
    nChecks++;
    if (r_out !== lastExp) begin
      nFails++;
      $display("[TB] FAIL %s read_hold: got %h expected %h", tag, r_out, lastExp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    nChecks++;
    if (state !== 2'd0 || done !== 1'b0 || irq !== 1'b0 || r_out !== '0 || trig_index !== '0) begin
      nFails++;
      $display("[TB] FAIL %s reset_outputs: got state=%0d done=%b irq=%b r_out=%h trig_index=%0d expected 0/0/0/00/0",
               tag, state, done, irq, r_out, trig_index);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_in = '0; arm = 0; abort = 0; trig_mask = '0; trig_value = '0; trig_edge = 0;
    pre_count = '0; irq_clear = 0; r_enable = 0; r_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");
  endtask

  task automatic test_ramp();
    int t;
    for (int k = 0; k < N; k++) hist[k] = W'(8'h10 + k);
    run_capture(4, 1'b0, 8'hFF, 8'h20, 1'b0, "ramp", t);
    check_readout(t, 4, "ramp");
    r_enable = 1'b1; r_addr = 4'd15;
    @(posedge clk); @(negedge clk);
    r_enable = 1'b0;
    nChecks++;
    if (r_out !== 8'h2B) begin
      nFails++;
      $display("[TB] FAIL ramp read15_const: got %h expected 2b", r_out);
    end
  endtask

  task automatic test_edge();
    int t;
    for (int k = 0; k < N; k++) hist[k] = W'($urandom_range(0, 255));
    for (int k = 0; k < 10; k++) hist[k] = 8'h55;
    for (int k = 10; k < 13; k++) hist[k] = 8'h00;
    hist[13] = 8'h55;
    s_in = 8'h55;
    run_capture(2, 1'b1, 8'hFF, 8'h55, 1'b0, "edge", t);
    check_readout(t, 2, "edge");
  endtask

  // A requested pre of 31 cannot be expressed on the 4-bit port; it arrives as the
  // clamped maximum of 15, so the trigger sample completes the buffer.
  task automatic test_clamp();
    int t;
    for (int k = 0; k < N; k++) begin
      hist[k] = W'($urandom_range(0, 255));
      if (hist[k] == 8'hA5) hist[k] = 8'h5A;
    end
    hist[22] = 8'hA5;
    run_capture(15, 1'b0, 8'hFF, 8'hA5, 1'b0, "clamp", t);
    check_readout(t, 15, "clamp");
  endtask

  task automatic test_random();
    int t, pre, tries;
    bit edgeMode;
    logic [W-1:0] mask, value;
    for (int it = 0; it < 4; it++) begin
      tries = 0;
      do begin
        pre      = $urandom_range(0, 15);
        mask     = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
        edgeMode = (mask == '0) ? 1'b0 : 1'($urandom_range(0, 1));
        value    = W'($urandom);
        for (int k = 0; k < N; k++) begin
          case ($urandom_range(0, 3))
            0:       hist[k] = value;
            1:       hist[k] = value ^ 8'h01;
            default: hist[k] = W'($urandom);
          endcase
        end
        t = find_trigger(pre, edgeMode, mask, value);
        tries++;
      end while ((t < 0 || t + DEPTH - pre >= N - 1) && tries < 50);
      if (t < 0 || t + DEPTH - pre >= N - 1) begin
        mask = '0; edgeMode = 1'b0;
      end
      run_capture(pre, edgeMode, mask, value, 1'b0, $sformatf("random%0d", it), t);
      check_readout(t, pre, $sformatf("random%0d", it));
    end
  endtask

  task automatic test_irq_clear();
    int t;
    @(negedge clk);
    irq_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    irq_clear = 1'b0;
    nChecks++;
    if (irq !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL irqclr cleared: got %b expected 0", irq);
    end
    for (int k = 0; k < N; k++) hist[k] = W'(k * 3);
    run_capture(6, 1'b0, 8'hF0, 8'h30, 1'b1, "irqclr", t);
    @(negedge clk);
    irq_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    irq_clear = 1'b0;
    nChecks++;
    if (irq !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL irqclr second_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_abort();
    int t;
    @(negedge clk);
    arm = 1'b1; pre_count = '0; trig_mask = 8'hFF; trig_value = 8'hAA; trig_edge = 1'b0;
    @(posedge clk); @(negedge clk);
    arm = 1'b0;
    s_in = 8'h00;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    nChecks++;
    if (state !== 2'd2) begin
      nFails++;
      $display("[TB] FAIL abort in_wait: got %0d expected 2", state);
    end
    abort = 1'b1; arm = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0; arm = 1'b0;
    nChecks++;
    if (state !== 2'd0 || done !== 1'b0 || irq !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL abort idle: got state=%0d done=%b irq=%b expected 0/0/0", state, done, irq);
    end
    @(posedge clk); @(negedge clk);
    nChecks++;
    if (state !== 2'd0) begin
      nFails++;
      $display("[TB] FAIL abort stays_idle: got %0d expected 0", state);
    end
    for (int k = 0; k < N; k++) hist[k] = W'($urandom);
    hist[30] = 8'hC3;
    hist[31] = 8'hC3;
    run_capture(7, 1'b0, 8'hFF, 8'hC3, 1'b0, "after_abort", t);
    check_readout(t, 7, "after_abort");
  endtask

  task automatic test_reset_mid_post();
    @(negedge clk);
    arm = 1'b1; pre_count = 4'd4; trig_mask = 8'hFF; trig_value = 8'h20; trig_edge = 1'b0;
    @(posedge clk); @(negedge clk);
    arm = 1'b0;
    for (int k = 0; k < 20; k++) begin
      s_in = W'(8'h10 + k);
      @(posedge clk); @(negedge clk);
    end
    nChecks++;
    if (state !== 2'd3 || done !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midpost in_post: got state=%0d done=%b expected 3/0", state, done);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midpost");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midpost_release");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_edge();
    test_clamp();
    test_random();
    test_irq_clear();
    test_abort();
    test_reset_mid_post();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
